mips_multicycle_ctrl: RTL

//  Main control FSM that sequences the shared MIPS datapath in multicycle mode: one ALU and one

---
 rtl/mips_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM sequencing the shared multicycle MIPS datapath.
// Optional build macro MEM_WAIT_EN: memory states hold until i_mem_ready.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_iord,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [2:0]       o_alu_ctrl,
    output logic [1:0]       o_pc_src,
    output logic             o_pc_en,
    output logic             o_illegal_op,
    output logic [CNT_W-1:0] o_instr_cnt
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_retire;
    logic       w_mem_ok;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_r;
    logic       w_is_beq;
    logic       w_is_addi;
    logic       w_is_j;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;

`ifdef MEM_WAIT_EN
    assign w_mem_ok = i_mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = i_mem_ready;
    assign w_mem_ok = 1'b1;
`endif

    assign w_is_lw   = (i_opcode == OP_LW);
    assign w_is_sw   = (i_opcode == OP_SW);
    assign w_is_r    = (i_opcode == OP_R);
    assign w_is_beq  = (i_opcode == OP_BEQ);
    assign w_is_addi = (i_opcode == OP_ADDI);
    assign w_is_j    = (i_opcode == OP_J);

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_AND;
        unique case (i_funct)
            FN_ADD: w_funct_alu = ALU_ADD;
            FN_SUB: w_funct_alu = ALU_SUB;
            FN_AND: w_funct_alu = ALU_AND;
            FN_OR:  w_funct_alu = ALU_OR;
            FN_SLT: w_funct_alu = ALU_SLT;
            default: w_funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_retire     = 1'b0;
        o_iord       = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = 2'b00;
        o_alu_ctrl   = ALU_AND;
        o_pc_src     = 2'b00;
        o_illegal_op = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                o_alu_src_b = 2'b01;
                o_alu_ctrl  = ALU_ADD;
                o_ir_write  = w_mem_ok;
                w_pc_write  = w_mem_ok;
                if (w_mem_ok) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                o_alu_src_b = 2'b11;
                o_alu_ctrl  = ALU_ADD;
                unique case (1'b1)
                    w_is_lw,
                    w_is_sw:   w_next = S_MEMADR;
                    w_is_r:    w_next = S_EXEC;
                    w_is_beq:  w_next = S_BRANCH;
                    w_is_addi: w_next = S_ADDIEX;
                    w_is_j:    w_next = S_JUMP;
                    default: begin
                        o_illegal_op = 1'b1;
                        w_next       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_ctrl  = ALU_ADD;
                w_next      = w_is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
                if (w_mem_ok) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = w_mem_ok;
                if (w_mem_ok) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_ctrl  = w_funct_alu;
                if (w_funct_ok) begin
                    w_next = S_ALUWB;
                end else begin
                    o_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_ALUWB: begin
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_ctrl  = ALU_SUB;
                o_pc_src    = 2'b01;
                w_branch    = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                o_alu_ctrl  = ALU_ADD;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                o_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                o_pc_src   = 2'b10;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign o_pc_en     = w_pc_write | (w_branch & i_zero);
    assign o_instr_cnt = r_cnt;

endmodule
